aes_cipher_iter: RTL and testbench

Iterative AES forward cipher (encryption) per FIPS-197, for AES-128, AES-192 and AES-256 selected by nk. It is the encrypt-direction counterpart of the team's inverse-cipher datapath. The block takes a plaintext block and the fully expanded key schedule, and runs one round per clock. It sits between the KeyExpansion block, which supplies round_keys, and the system data path.

---
 rtl/aes_cipher_iter.sv | 148 ++++++++++++++
 tb/tb_aes_cipher_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_cipher_iter
// Purpose  : Iterative AES-128/192/256 forward cipher, one round per clock,
//            driven by an externally supplied expanded key schedule.
// Revision : 1.0 - initial release
// ============================================================================
module aes_cipher_iter #(
    parameter int nk = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [127:0]           state_in,
    input  logic [128*(nk+7)-1:0]  round_keys,
    output logic                   busy,
    output logic                   done,
    output logic [127:0]           state_out
);

    localparam int         c_NR   = nk + 6;
    localparam logic [3:0] c_NR_4 = 4'(c_NR);

    generate
        if (nk != 4 && nk != 6 && nk != 8) begin : g_bad_nk
            $error("aes_cipher_iter: nk must be 4, 6 or 8");
        end
    endgenerate

    // Forward S-box, byte b at bits [2047-8*b -: 8]
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_fsm;
    logic [3:0]     r_round;
    logic [127:0]   r_state;
    logic [127:0]   w_rk;
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block lives at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    always_comb begin
        w_rk = '0;
        for (int i = 0; i <= c_NR; i++) begin
            if (r_round == 4'(i)) begin
                w_rk = round_keys[128*i +: 128];
            end
        end
    end

    assign w_sr = sub_shift(r_state);
    assign w_mc = mix_columns(w_sr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm     <= IDLE;
            r_round   <= 4'd0;
            r_state   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= state_in ^ round_keys[127:0];
                        r_round <= 4'd1;
                        busy    <= 1'b1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    if (r_round == c_NR_4) begin
                        state_out <= w_sr ^ w_rk;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_round   <= 4'd0;
                        r_fsm     <= IDLE;
                    end else begin
                        r_state <= w_mc ^ w_rk;
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_cipher_iter
// Purpose  : Directed FIPS-197 vector bench for aes_cipher_iter (nk=4/6/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_iter;

    localparam logic [255:0] c_KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] c_KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_CT_C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT_C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_CT_C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     start_v;
    logic [127:0]   state_in;
    logic [1407:0]  rk4;
    logic [1663:0]  rk6;
    logic [1919:0]  rk8;
    logic [2:0]     busy_v;
    logic [2:0]     done_v;
    logic [127:0]   out_v [3];

    logic [7:0]     sb [256];
    int             n_vec = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    aes_cipher_iter #(.nk(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .state_in(state_in),
        .round_keys(rk4), .busy(busy_v[0]), .done(done_v[0]), .state_out(out_v[0])
    );
    aes_cipher_iter #(.nk(6)) u_dut6 (
        .clk(clk), .reset(reset), .start(start_v[1]), .state_in(state_in),
        .round_keys(rk6), .busy(busy_v[1]), .done(done_v[1]), .state_out(out_v[1])
    );
    aes_cipher_iter #(.nk(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start_v[2]), .state_in(state_in),
        .round_keys(rk8), .busy(busy_v[2]), .done(done_v[2]), .state_out(out_v[2])
    );

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box derived algebraically: multiplicative inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nkv, output logic [1919:0] rk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nkv + 6;
        rc = 8'h01;
        rk = '0;
        for (int i = 0; i < nkv; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nkv; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nkv == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nkv > 6 && i % nkv == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nkv] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Start one block on instance idx; returns ciphertext, edges to done and busy cycles.
    task automatic run_block(input int idx, input logic [127:0] pt,
                             output logic [127:0] ct, output int lat, output int bcnt);
        state_in     = pt;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        state_in     = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        lat  = 0;
        bcnt = 0;
        ct   = '0;
        while (!done_v[idx] && lat < 40) begin
            bcnt += int'(busy_v[idx]);
            tick();
            lat++;
        end
        if (done_v[idx]) ct = out_v[idx];
        else lat = -1;
    endtask

    initial begin
        logic [1919:0] tmp;
        logic [127:0]  ct;
        logic [127:0]  first_ct;
        int            lat, bcnt, ndone, done_cyc;

        reset    = 1'b1;
        start_v  = 3'b000;
        state_in = '0;
        build_sbox();
        expand(c_KEY_B, 4, tmp); rk4 = tmp[1407:0];
        expand(c_KEY_C, 6, tmp); rk6 = tmp[1663:0];
        expand(c_KEY_C, 8, tmp); rk8 = tmp;
        repeat (3) tick();
        check_vec("reset_busy", 128'(busy_v[0]), 128'd0);
        check_vec("reset_done", 128'(done_v[0]), 128'd0);
        check_vec("reset_out",  out_v[0], 128'd0);
        reset = 1'b0;
        tick();

        // App. B, AES-128
        run_block(0, c_PT_B, ct, lat, bcnt);
        check_vec("appB_ct",   ct, c_CT_B);
        check_vec("appB_lat",  128'(lat), 128'd10);
        check_vec("appB_busy", 128'(bcnt), 128'd10);
        tick();
        check_vec("appB_done_pulse", 128'(done_v[0]), 128'd0);

        // App. C, all three key sizes
        expand(c_KEY_C, 4, tmp); rk4 = tmp[1407:0];
        run_block(0, c_PT_C, ct, lat, bcnt);
        check_vec("appC4_ct",  ct, c_CT_C4);
        check_vec("appC4_lat", 128'(lat), 128'd10);
        run_block(1, c_PT_C, ct, lat, bcnt);
        check_vec("appC6_ct",  ct, c_CT_C6);
        check_vec("appC6_lat", 128'(lat), 128'd12);
        run_block(2, c_PT_C, ct, lat, bcnt);
        check_vec("appC8_ct",  ct, c_CT_C8);
        check_vec("appC8_lat", 128'(lat), 128'd14);
        tick();

        // Start while busy must be ignored
        state_in   = c_PT_C;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        state_in   = c_PT_B;
        ndone = 0; done_cyc = -1; ct = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            start_v[0] = (cyc == 3);
            tick();
            if (done_v[0]) begin
                ndone++;
                if (done_cyc < 0) begin done_cyc = cyc; ct = out_v[0]; end
            end
        end
        start_v[0] = 1'b0;
        check_vec("busy_start_ndone", 128'(ndone), 128'd1);
        check_vec("busy_start_ct",    ct, c_CT_C4);
        check_vec("busy_start_lat",   128'(done_cyc), 128'd10);

        // Back-to-back: second start held during the done cycle
        run_block(0, c_PT_C, first_ct, lat, bcnt);
        check_vec("b2b_first_ct", first_ct, c_CT_C4);
        expand(c_KEY_B, 4, tmp); rk4 = tmp[1407:0];
        state_in   = c_PT_B;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check_vec("b2b_accept_busy", 128'(busy_v[0]), 128'd1);
        lat = 0;
        while (!done_v[0] && lat < 40) begin
            check_vec("b2b_hold", out_v[0], c_CT_C4);
            tick();
            lat++;
        end
        check_vec("b2b_second_lat", 128'(lat), 128'd10);
        check_vec("b2b_second_ct",  out_v[0], c_CT_B);

        // Reset in the middle of round 5
        tick();
        state_in   = c_PT_B;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_vec("mid_rst_busy", 128'(busy_v[0]), 128'd0);
        check_vec("mid_rst_done", 128'(done_v[0]), 128'd0);
        check_vec("mid_rst_out",  out_v[0], 128'd0);
        ndone = 0;
        repeat (15) begin
            tick();
            ndone += int'(done_v[0]);
        end
        check_vec("mid_rst_no_done", 128'(ndone), 128'd0);
        run_block(0, c_PT_B, ct, lat, bcnt);
        check_vec("post_rst_ct",  ct, c_CT_B);
        check_vec("post_rst_lat", 128'(lat), 128'd10);

        // Idle hold
        for (int i = 0; i < 20; i++) begin
            tick();
            check_vec("idle_out",  out_v[0], c_CT_B);
            check_vec("idle_done", 128'(done_v[0]), 128'd0);
            check_vec("idle_busy", 128'(busy_v[0]), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
